// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word reads to instruction
// memory under a credit limit, buffers in-order responses in a small FIFO
// and hands them to decode. Redirects flush the buffer and mark in-flight
// responses for discard.

// Protocol and occupancy checks for the fetch stage.
module fetch_unit_chk #(
    parameter int FIFO_DEPTH = 2,
    parameter int CW         = 2
) (
    input logic          clk,
    input logic          rst_n,
    input logic          imem_rsp_valid,
    input logic [CW-1:0] outstanding,
    input logic [CW-1:0] fifo_cnt
);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    a_rsp_needs_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
        imem_rsp_valid |-> (outstanding != '0));
    a_fifo_bound: assert property (@(posedge clk) disable iff (!rst_n)
        fifo_cnt <= DEPTH_C);
    a_outstanding_bound: assert property (@(posedge clk) disable iff (!rst_n)
        outstanding <= DEPTH_C);
endmodule

module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);
    localparam int            PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int            CW      = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0]   DEPTH_C = (CW + 1)'(FIFO_DEPTH);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    logic [31:0]   pc_q, pc_d;
    logic [31:0]   fifo_data_q [FIFO_DEPTH];
    logic [31:0]   fifo_data_d [FIFO_DEPTH];
    logic [31:0]   fifo_pc_q   [FIFO_DEPTH];
    logic [31:0]   fifo_pc_d   [FIFO_DEPTH];
    logic [PW-1:0] fifo_rd_q, fifo_rd_d, fifo_wr_q, fifo_wr_d;
    logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;
    logic [31:0]   iq_addr_q   [FIFO_DEPTH];
    logic [31:0]   iq_addr_d   [FIFO_DEPTH];
    logic [PW-1:0] iq_rd_q, iq_rd_d, iq_wr_q, iq_wr_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;

    logic credit_s, req_valid_s, req_fire_s, rsp_drop_s, push_s, pop_s;

    // Request credit and handshake qualifiers; credit looks only at registered counts.
    always_comb begin
        credit_s    = ({1'b0, outstanding_q} + {1'b0, fifo_cnt_q}) < DEPTH_C;
        req_valid_s = rst_n && !redirect_valid && credit_s;
        req_fire_s  = req_valid_s && imem_req_ready;
        rsp_drop_s  = redirect_valid || (drop_cnt_q != '0);
        push_s      = imem_rsp_valid && !rsp_drop_s;
        pop_s       = (fifo_cnt_q != '0) && instr_ready && !redirect_valid;
    end

    assign imem_req_valid = req_valid_s;
    assign imem_addr      = pc_q;

    // Next-state for PC, issued-address queue, counters and instruction FIFO.
    always_comb begin
        pc_d          = pc_q;
        fifo_data_d   = fifo_data_q;
        fifo_pc_d     = fifo_pc_q;
        fifo_rd_d     = fifo_rd_q;
        fifo_wr_d     = fifo_wr_q;
        fifo_cnt_d    = fifo_cnt_q;
        iq_addr_d     = iq_addr_q;
        iq_rd_d       = iq_rd_q;
        iq_wr_d       = iq_wr_q;
        drop_cnt_d    = drop_cnt_q;
        outstanding_d = outstanding_q + CW'(req_fire_s) - CW'(imem_rsp_valid);

        if (redirect_valid) begin
            pc_d = redirect_pc;
        end else if (req_fire_s) begin
            pc_d = pc_q + 32'd4;
        end else begin
            pc_d = pc_q;
        end

        // The address queue tracks every accepted request, even ones later dropped.
        if (req_fire_s) begin
            iq_addr_d[iq_wr_q] = pc_q;
            iq_wr_d            = iq_wr_q + PTR_ONE;
        end else begin
            iq_wr_d = iq_wr_q;
        end
        if (imem_rsp_valid) begin
            iq_rd_d = iq_rd_q + PTR_ONE;
        end else begin
            iq_rd_d = iq_rd_q;
        end

        if (redirect_valid) begin
            // Everything still in flight becomes stale, except a response landing now,
            // which is discarded directly.
            drop_cnt_d = outstanding_q - CW'(imem_rsp_valid);
        end else if (imem_rsp_valid && (drop_cnt_q != '0)) begin
            drop_cnt_d = drop_cnt_q - CW'(1'b1);
        end else begin
            drop_cnt_d = drop_cnt_q;
        end

        if (redirect_valid) begin
            fifo_rd_d  = '0;
            fifo_wr_d  = '0;
            fifo_cnt_d = '0;
        end else begin
            if (push_s) begin
                fifo_data_d[fifo_wr_q] = imem_rsp_data;
                fifo_pc_d[fifo_wr_q]   = iq_addr_q[iq_rd_q];
                fifo_wr_d              = fifo_wr_q + PTR_ONE;
            end else begin
                fifo_wr_d = fifo_wr_q;
            end
            if (pop_s) begin
                fifo_rd_d = fifo_rd_q + PTR_ONE;
            end else begin
                fifo_rd_d = fifo_rd_q;
            end
            fifo_cnt_d = fifo_cnt_q + CW'(push_s) - CW'(pop_s);
        end
    end

    // Head of the FIFO toward decode; zeros when nothing is buffered.
    always_comb begin
        instr_valid = (fifo_cnt_q != '0);
        if (fifo_cnt_q != '0) begin
            instr    = fifo_data_q[fifo_rd_q];
            instr_pc = fifo_pc_q[fifo_rd_q];
        end else begin
            instr    = 32'h0000_0000;
            instr_pc = 32'h0000_0000;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            fifo_rd_q     <= '0;
            fifo_wr_q     <= '0;
            fifo_cnt_q    <= '0;
            iq_rd_q       <= '0;
            iq_wr_q       <= '0;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data_q[i] <= 32'h0000_0000;
                fifo_pc_q[i]   <= 32'h0000_0000;
                iq_addr_q[i]   <= 32'h0000_0000;
            end
        end else begin
            pc_q          <= pc_d;
            fifo_rd_q     <= fifo_rd_d;
            fifo_wr_q     <= fifo_wr_d;
            fifo_cnt_q    <= fifo_cnt_d;
            iq_rd_q       <= iq_rd_d;
            iq_wr_q       <= iq_wr_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            fifo_data_q   <= fifo_data_d;
            fifo_pc_q     <= fifo_pc_d;
            iq_addr_q     <= iq_addr_d;
        end
    end

    fetch_unit_chk #(.FIFO_DEPTH(FIFO_DEPTH), .CW(CW)) u_chk (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_rsp_valid (imem_rsp_valid),
        .outstanding    (outstanding_q),
        .fifo_cnt       (fifo_cnt_q)
    );
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: an in-order instruction memory model with
// programmable latency answers requests; the main sequence checks outputs.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        instr_valid;
    logic        instr_ready = 1'b1;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;

    int total = 0;
    int bad = 0;

    fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    // Memory model state
    int          cyc = 0;
    int          last_due = 0;
    int          fire_cnt = 0;
    int          lat_fix = 1;
    bit          lat_rand = 1'b0;
    int          lat_v, due_v;
    logic [31:0] q_addr[$];
    int          q_due[$];

    // Record accepted requests just before the edge that accepts them.
    always @(negedge clk) begin
        if (!rst_n) begin
            last_due = 0;
            fire_cnt = 0;
        end else if (imem_req_valid && imem_req_ready) begin
            lat_v = lat_rand ? int'($urandom_range(1, 3)) : lat_fix;
            due_v = cyc + lat_v;
            if (due_v <= last_due) due_v = last_due + 1;
            q_addr.push_back(imem_addr);
            q_due.push_back(due_v);
            last_due = due_v;
            fire_cnt = fire_cnt + 1;
        end
    end

    // Drive in-order responses once their due cycle arrives.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (!rst_n) begin
            q_addr.delete();
            q_due.delete();
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end else if (q_addr.size() != 0 && q_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(q_addr[0]);
            void'(q_addr.pop_front());
            void'(q_due.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        #1;
    endtask

    logic [31:0] exp_pc;
    int          got;
    bit          seen;

    initial begin
        // Reset state
        repeat (3) step();
        chk("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
        chk("rst_instr_valid", {31'h0, instr_valid}, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_instr_pc", instr_pc, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);

        // Streaming, 1-cycle memory, decode always ready
        rst_n = 1'b1;
        #1;
        chk("t1_req0", {31'h0, imem_req_valid}, 32'h1);
        chk("t1_addr0", imem_addr, 32'h0);
        step();
        chk("t1_e1_addr", imem_addr, 32'h4);
        chk("t1_e1_ivalid", {31'h0, instr_valid}, 32'h0);
        step();
        chk("t1_e2_ivalid", {31'h0, instr_valid}, 32'h1);
        chk("t1_e2_pc", instr_pc, 32'h0);
        chk("t1_e2_instr", instr, mem_word(32'h0));
        chk("t1_e2_nocredit", {31'h0, imem_req_valid}, 32'h0);
        step();
        chk("t1_e3_pc", instr_pc, 32'h4);
        chk("t1_e3_instr", instr, mem_word(32'h4));
        chk("t1_e3_req", {31'h0, imem_req_valid}, 32'h1);
        chk("t1_e3_addr", imem_addr, 32'h8);
        step();
        chk("t1_e4_ivalid", {31'h0, instr_valid}, 32'h0);
        chk("t1_e4_addr", imem_addr, 32'hC);
        step();
        chk("t1_e5_pc", instr_pc, 32'h8);
        chk("t1_e5_nocredit", {31'h0, imem_req_valid}, 32'h0);

        // Backpressure from decode
        instr_ready = 1'b0;
        do_reset();
        step();
        step();
        step();
        step();
        chk("t2_req_blocked", {31'h0, imem_req_valid}, 32'h0);
        chk("t2_fires", fire_cnt, 32'd2);
        chk("t2_head", instr_pc, 32'h0);
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        chk("t2_pop_head", instr_pc, 32'h4);
        chk("t2_req_after_pop", {31'h0, imem_req_valid}, 32'h1);
        chk("t2_addr_after_pop", imem_addr, 32'h8);
        chk("t2_fires_b", fire_cnt, 32'd2);
        step();
        chk("t2_fires_c", fire_cnt, 32'd3);
        chk("t2_req_blocked_b", {31'h0, imem_req_valid}, 32'h0);

        // Redirect with two responses in flight
        instr_ready = 1'b1;
        lat_fix = 3;
        do_reset();
        step();
        step();
        chk("t3_two_inflight", {31'h0, imem_req_valid}, 32'h0);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0100;
        step();
        redirect_valid = 1'b0;
        chk("t3_ivalid0", {31'h0, instr_valid}, 32'h0);
        chk("t3_addr", imem_addr, 32'h100);
        chk("t3_drop_cnt", {30'h0, dut.drop_cnt_q}, 32'd2);
        step();
        chk("t3_ivalid1", {31'h0, instr_valid}, 32'h0);
        chk("t3_req_after", {31'h0, imem_req_valid}, 32'h1);
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            step();
            if (instr_valid) begin
                seen = 1'b1;
                chk("t3_first_pc", instr_pc, 32'h100);
                chk("t3_first_instr", instr, mem_word(32'h100));
            end
        end
        chk("t3_delivered", {31'h0, seen}, 32'h1);

        // Redirect coinciding with a response and a pop
        lat_fix = 1;
        do_reset();
        step();
        step();
        chk("t4_setup_pc", instr_pc, 32'h0);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0200;
        step();
        redirect_valid = 1'b0;
        chk("t4_ivalid", {31'h0, instr_valid}, 32'h0);
        chk("t4_instr", instr, 32'h0);
        chk("t4_drop_cnt", {30'h0, dut.drop_cnt_q}, 32'd0);
        chk("t4_outstanding", {30'h0, dut.outstanding_q}, 32'd0);
        chk("t4_addr", imem_addr, 32'h200);
        step();
        chk("t4_ivalid_b", {31'h0, instr_valid}, 32'h0);
        step();
        chk("t4_first_pc", instr_pc, 32'h200);

        // Random memory latency with request-ready toggling
        lat_rand = 1'b1;
        do_reset();
        exp_pc = 32'h0;
        got = 0;
        for (int i = 0; i < 3000 && got < 100; i++) begin
            step();
            imem_req_ready = i[0];
            instr_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (instr_valid && instr_ready) begin
                chk("t5_seq_pc", instr_pc, exp_pc);
                exp_pc = exp_pc + 32'd4;
                got++;
            end
        end
        chk("t5_count", got, 32'd100);

        // Reset asserted mid-stream
        lat_rand = 1'b0;
        lat_fix = 1;
        imem_req_ready = 1'b1;
        instr_ready = 1'b1;
        repeat (5) step();
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_ivalid", {31'h0, instr_valid}, 32'h0);
        chk("t6_instr", instr, 32'h0);
        chk("t6_ipc", instr_pc, 32'h0);
        chk("t6_req", {31'h0, imem_req_valid}, 32'h0);
        chk("t6_addr", imem_addr, 32'h0);
        step();
        step();
        rst_n = 1'b1;
        #1;
        chk("t6_req_rel", {31'h0, imem_req_valid}, 32'h1);
        chk("t6_addr_rel", imem_addr, 32'h0);
        step();
        step();
        chk("t6_first_ivalid", {31'h0, instr_valid}, 32'h1);
        chk("t6_first_pc", instr_pc, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
